// File: rtl/vx_om_req_serializer.sv
// Serializes one NUM_LANES-wide OM request into per-lane pixel requests, lowest lane first.
// All-zero-mask requests are consumed silently; back-to-back requests run without bubbles.
module vx_om_req_serializer #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DIM_BITS   = 11,
  parameter int unsigned DEPTH_BITS = 24,
  parameter int unsigned UUID_WIDTH = 1,
  localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [UUID_WIDTH-1:0]            in_uuid,
  input  logic [NUM_LANES-1:0]             in_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0]    in_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]    in_pos_y,
  input  logic [NUM_LANES*32-1:0]          in_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0]  in_depth,
  input  logic [NUM_LANES-1:0]             in_face,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [UUID_WIDTH-1:0]            out_uuid,
  output logic [LANE_W-1:0]                out_lane,
  output logic [DIM_BITS-1:0]              out_pos_x,
  output logic [DIM_BITS-1:0]              out_pos_y,
  output logic [31:0]                      out_color,
  output logic [DEPTH_BITS-1:0]            out_depth,
  output logic                             out_face,
  output logic                             out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [NUM_LANES-1:0]              pending_q, pending_d;
  logic [UUID_WIDTH-1:0]             uuid_q;
  logic [NUM_LANES*DIM_BITS-1:0]     pos_x_q, pos_y_q;
  logic [NUM_LANES*32-1:0]           color_q;
  logic [NUM_LANES*DEPTH_BITS-1:0]   depth_q;
  logic [NUM_LANES-1:0]              face_q;

  logic                              accept_c, fire_c, load_c, last_c;
  logic [NUM_LANES-1:0]              sel_onehot_c;

  // Lowest pending lane drives the pixel fields; pending==0 leaves every field at 0.
  always_comb begin
    out_lane  = '0;
    out_pos_x = '0;
    out_pos_y = '0;
    out_color = '0;
    out_depth = '0;
    out_face  = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        out_lane  = LANE_W'(i);
        out_pos_x = pos_x_q[i*DIM_BITS +: DIM_BITS];
        out_pos_y = pos_y_q[i*DIM_BITS +: DIM_BITS];
        out_color = color_q[i*32 +: 32];
        out_depth = depth_q[i*DEPTH_BITS +: DEPTH_BITS];
        out_face  = face_q[i];
      end
    end
  end

  assign sel_onehot_c = pending_q & (~pending_q + NUM_LANES'(1));
  assign last_c       = (pending_q & (pending_q - NUM_LANES'(1))) == '0;

  assign out_valid = (state_q == BUSY);
  assign out_last  = out_valid & last_c;
  assign out_uuid  = out_valid ? uuid_q : '0;

  // in_ready looks through out_ready so the next request loads on the last pixel.
  assign in_ready = (state_q == IDLE) | (out_valid & out_ready & out_last);
  assign accept_c = in_valid & in_ready;
  assign fire_c   = out_valid & out_ready;
  assign load_c   = accept_c & (|in_mask);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (fire_c) begin
      pending_d = pending_q & ~sel_onehot_c;
      if (out_last) begin
        state_d = IDLE;
      end
    end
    if (accept_c) begin
      pending_d = in_mask;
      state_d   = (|in_mask) ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      uuid_q    <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      color_q   <= '0;
      depth_q   <= '0;
      face_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load_c) begin
        uuid_q  <= in_uuid;
        pos_x_q <= in_pos_x;
        pos_y_q <= in_pos_y;
        color_q <= in_color;
        depth_q <= in_depth;
        face_q  <= in_face;
      end
    end
  end

endmodule

// File: tb/tb_vx_om_req_serializer.sv
// Bench for vx_om_req_serializer: a queue of expected pixels built from each accepted mask,
// checked every cycle, plus directed scenarios with hand-computed lane sequences.
module tb_vx_om_req_serializer;

  localparam int unsigned NL = 4;
  localparam int unsigned DB = 11;
  localparam int unsigned ZB = 24;
  localparam int unsigned UW = 1;
  localparam int unsigned LW = 2;
  localparam int unsigned N_RAND = 10000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready;
  logic [UW-1:0]     in_uuid;
  logic [NL-1:0]     in_mask;
  logic [NL*DB-1:0]  in_pos_x, in_pos_y;
  logic [NL*32-1:0]  in_color;
  logic [NL*ZB-1:0]  in_depth;
  logic [NL-1:0]     in_face;
  logic              out_valid, out_ready;
  logic [UW-1:0]     out_uuid;
  logic [LW-1:0]     out_lane;
  logic [DB-1:0]     out_pos_x, out_pos_y;
  logic [31:0]       out_color;
  logic [ZB-1:0]     out_depth;
  logic              out_face, out_last;

  vx_om_req_serializer #(
    .NUM_LANES(NL), .DIM_BITS(DB), .DEPTH_BITS(ZB), .UUID_WIDTH(UW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_mask(in_mask),
    .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_color(in_color), .in_depth(in_depth),
    .in_face(in_face),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_lane(out_lane),
    .out_pos_x(out_pos_x), .out_pos_y(out_pos_y), .out_color(out_color),
    .out_depth(out_depth), .out_face(out_face), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] lane;
    logic [DB-1:0] x;
    logic [DB-1:0] y;
    logic [31:0]   color;
    logic [ZB-1:0] depth;
    logic          face;
    logic [UW-1:0] uuid;
  } pix_t;

  pix_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_accepted = 0;
  logic          obs_valid, obs_last, obs_ir;
  logic [LW-1:0] obs_lane;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [NL-1:0] m, input logic ordy);
    in_valid  = v;
    in_mask   = m;
    out_ready = ordy;
    in_uuid   = UW'($urandom);
    in_face   = NL'($urandom);
    for (int i = 0; i < NL; i++) begin
      in_pos_x[i*DB +: DB] = DB'($urandom);
      in_pos_y[i*DB +: DB] = DB'($urandom);
      in_color[i*32 +: 32] = $urandom;
      in_depth[i*ZB +: ZB] = ZB'($urandom);
    end
  endtask

  // Called at posedge+1 with inputs set; checks outputs, then advances the model past the edge.
  task automatic step();
    logic exp_ir, fire, acc;
    pix_t p;
    pix_t newq[$];
    #2;
    exp_ir = (q.size() == 0) || (out_ready && q.size() == 1);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      p = q[0];
      chk("out_lane", 64'(out_lane), 64'(p.lane));
      chk("out_pos_x", 64'(out_pos_x), 64'(p.x));
      chk("out_pos_y", 64'(out_pos_y), 64'(p.y));
      chk("out_color", 64'(out_color), 64'(p.color));
      chk("out_depth", 64'(out_depth), 64'(p.depth));
      chk("out_face", 64'(out_face), 64'(p.face));
      chk("out_uuid", 64'(out_uuid), 64'(p.uuid));
      chk("out_last", 64'(out_last), 64'(q.size() == 1));
    end else begin
      chk("idle_last", 64'(out_last), 64'd0);
      chk("idle_fields", 64'({out_lane, out_pos_x, out_depth}), 64'd0);
    end
    obs_valid = out_valid;
    obs_last  = out_last;
    obs_lane  = out_lane;
    obs_ir    = in_ready;
    fire = (q.size() != 0) && out_ready;
    acc  = in_valid && exp_ir;
    if (acc) begin
      n_accepted++;
      for (int i = 0; i < NL; i++) begin
        if (in_mask[i]) begin
          p.lane  = LW'(i);
          p.x     = in_pos_x[i*DB +: DB];
          p.y     = in_pos_y[i*DB +: DB];
          p.color = in_color[i*32 +: 32];
          p.depth = in_depth[i*ZB +: ZB];
          p.face  = in_face[i];
          p.uuid  = in_uuid;
          newq.push_back(p);
        end
      end
    end
    @(posedge clk);
    #1;
    if (fire) void'(q.pop_front());
    foreach (newq[k]) q.push_back(newq[k]);
  endtask

  initial begin
    int cyc;
    logic [LW-1:0] lanes[4];
    logic          lasts[4];

    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_fields", 64'({out_pos_x, out_pos_y, out_depth}), 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: mask 1011 -> lanes 0,1,3
    drive(1'b1, 4'b1011, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      lanes[k] = obs_lane;
      lasts[k] = obs_last;
    end
    chk("s1_lane0", 64'(lanes[0]), 64'd0);
    chk("s1_lane1", 64'(lanes[1]), 64'd1);
    chk("s1_lane2", 64'(lanes[2]), 64'd3);
    chk("s1_lasts", 64'({lasts[0], lasts[1], lasts[2]}), 64'b001);
    step();
    chk("s1_idle", 64'(obs_valid), 64'd0);

    // Scenario 2: zero mask dropped, then single lane 2
    drive(1'b1, 4'b0000, 1'b1);
    step();
    drive(1'b1, 4'b0100, 1'b1);
    step();
    chk("s2_no_pixel", 64'(obs_valid), 64'd0);
    drive(1'b0, '0, 1'b1);
    step();
    chk("s2_pix", 64'({obs_valid, obs_lane, obs_last}), 64'({1'b1, 2'd2, 1'b1}));

    // Scenario 3: 1111 then 0001 back to back
    drive(1'b1, 4'b1111, 1'b1);
    step();
    drive(1'b1, 4'b0001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      lanes[k] = obs_lane;
      lasts[k] = obs_ir;
    end
    chk("s3_lanes", 64'({lanes[0], lanes[1], lanes[2], lanes[3]}), 64'b00_01_10_11);
    chk("s3_ready", 64'({lasts[0], lasts[1], lasts[2], lasts[3]}), 64'b0001);
    drive(1'b0, '0, 1'b1);
    step();
    chk("s3_fifth", 64'({obs_valid, obs_lane, obs_last}), 64'({1'b1, 2'd0, 1'b1}));
    step();

    // Scenario 4: mask 0110 with stalls
    drive(1'b1, 4'b0110, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    lanes[0] = obs_lane;
    drive(1'b0, '0, 1'b0);
    step();
    lanes[1] = obs_lane;
    lasts[1] = obs_ir;
    step();
    lanes[2] = obs_lane;
    lasts[2] = obs_ir;
    drive(1'b0, '0, 1'b1);
    step();
    lanes[3] = obs_lane;
    lasts[3] = obs_last;
    chk("s4_lanes", 64'({lanes[0], lanes[1], lanes[2], lanes[3]}), 64'b01_10_10_10);
    chk("s4_stall_ready", 64'({lasts[1], lasts[2]}), 64'b00);
    chk("s4_last", 64'(lasts[3]), 64'd1);
    step();
    chk("s4_no_dup", 64'(obs_valid), 64'd0);

    // Scenario 5: reset mid-request
    drive(1'b1, 4'b1111, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    chk("s5_first", 64'(obs_lane), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("s5_async_valid", 64'(out_valid), 64'd0);
    chk("s5_rst_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("s5_nothing", 64'(obs_valid), 64'd0);

    // Scenario 6: randomized traffic
    n_accepted = 0;
    cyc = 0;
    while (n_accepted < N_RAND && cyc < 90000) begin
      drive(($urandom_range(0, 7) != 0), NL'($urandom), ($urandom_range(0, 7) != 0));
      step();
      cyc++;
    end
    chk("rand_budget", 64'(n_accepted >= N_RAND), 64'd1);
    drive(1'b0, '0, 1'b1);
    repeat (NL + 2) step();
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
